// File: rtl/seq_stim_gen.sv
// -----------------------------------------------------------------------------
// seq_stim_gen
//   Driver for the enable/sequence checker. A start request in IDLE runs one
//   transaction through phases A -> C -> B -> D, each held PHASE_LEN cycles.
//   While the transaction runs, qualified din samples are accumulated into
//   data with saturation at DATA_MAX. When a transaction finishes, enable
//   ownership is handed over make-before-break: both enables are high for one
//   cycle, then only the new owner's enable is high.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   transaction request, sampled only in IDLE
//   din        in   [DATA_W] sample to accumulate
//   din_valid  in   din qualifier (ignored in IDLE)
//   busy       out  FSM not IDLE
//   a/c/b/d    out  phase strobes, exactly one high while busy
//   done       out  one-cycle pulse on the last cycle of phase D
//   data       out  [DATA_W] saturating accumulator
//   sat        out  sticky clip flag for the current/last transaction
//   enable_1   out  owner-1 enable
//   enable_2   out  owner-2 enable
// -----------------------------------------------------------------------------
module seq_stim_gen #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DATA_MAX  = 200,
  parameter int unsigned PHASE_LEN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              busy,
  output logic              a,
  output logic              c,
  output logic              b,
  output logic              d,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              sat,
  output logic              enable_1,
  output logic              enable_2
);

  typedef enum logic [2:0] {
    IDLE,
    PH_A,
    PH_C,
    PH_B,
    PH_D
  } state_t;

  localparam logic [3:0]        LP_RELOAD = 4'(PHASE_LEN - 1);
  localparam logic [DATA_W:0]   LP_MAX_W  = (DATA_W + 1)'(DATA_MAX);
  localparam logic [DATA_W-1:0] LP_MAX    = DATA_W'(DATA_MAX);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cnt;
  logic [3:0]        w_next_cnt;
  logic              w_last;

  logic              r_busy, r_a, r_c, r_b, r_d, r_done;
  logic              w_busy, w_a, w_c, w_b, w_d, w_done;

  logic [DATA_W-1:0] r_data;
  logic              r_sat;
  logic [DATA_W:0]   w_sum;
  logic              w_clip;
  logic              w_enter;
  logic              w_leave;

  logic              r_en1, r_en2;
  logic              r_owner;   // 0: owner-1 holds the enable, 1: owner-2
  logic              r_ho;      // both enables currently high, flip next edge

  // Phase counter holds remaining cycles in the current phase; 0 = last cycle.
  assign w_last  = (r_cnt == '0);
  assign w_enter = (r_state == IDLE) && start;
  assign w_leave = (r_state == PH_D) && w_last;

  // ---------------------------------------------------------------------------
  // State register (plus registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_a     <= 1'b0;
      r_c     <= 1'b0;
      r_b     <= 1'b0;
      r_d     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_busy  <= w_busy;
      r_a     <= w_a;
      r_c     <= w_c;
      r_b     <= w_b;
      r_d     <= w_d;
      r_done  <= w_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = PH_A;
          w_next_cnt   = LP_RELOAD;
        end
      end
      PH_A: begin
        if (w_last) begin
          w_next_state = PH_C;
          w_next_cnt   = LP_RELOAD;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      PH_C: begin
        if (w_last) begin
          w_next_state = PH_B;
          w_next_cnt   = LP_RELOAD;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      PH_B: begin
        if (w_last) begin
          w_next_state = PH_D;
          w_next_cnt   = LP_RELOAD;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      PH_D: begin
        if (w_last) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so the registered strobes line
  // up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy = (w_next_state != IDLE);
    w_a    = (w_next_state == PH_A);
    w_c    = (w_next_state == PH_C);
    w_b    = (w_next_state == PH_B);
    w_d    = (w_next_state == PH_D);
    w_done = (w_next_state == PH_D) && (w_next_cnt == '0);
  end

  // ---------------------------------------------------------------------------
  // Saturating accumulator
  // ---------------------------------------------------------------------------
  assign w_sum  = {1'b0, r_data} + {1'b0, din};
  assign w_clip = (w_sum > LP_MAX_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_sat  <= 1'b0;
    end else if (w_enter) begin
      r_data <= '0;
      r_sat  <= 1'b0;
    end else if ((r_state != IDLE) && din_valid) begin
      r_data <= w_clip ? LP_MAX : w_sum[DATA_W-1:0];
      if (w_clip) begin
        r_sat <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Enable handover: overlap cycle right after done, then hand to new owner.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en1   <= 1'b1;
      r_en2   <= 1'b0;
      r_owner <= 1'b0;
      r_ho    <= 1'b0;
    end else if (w_leave) begin
      r_en1 <= 1'b1;
      r_en2 <= 1'b1;
      r_ho  <= 1'b1;
    end else if (r_ho) begin
      r_owner <= ~r_owner;
      r_en1   <= r_owner;
      r_en2   <= ~r_owner;
      r_ho    <= 1'b0;
    end
  end

  assign busy     = r_busy;
  assign a        = r_a;
  assign c        = r_c;
  assign b        = r_b;
  assign d        = r_d;
  assign done     = r_done;
  assign data     = r_data;
  assign sat      = r_sat;
  assign enable_1 = r_en1;
  assign enable_2 = r_en2;

endmodule
